// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner_if
//  Description : Bundle between the display-data producer and the 7-segment
//                scanner. The producer loads digit data with a 1-cycle strobe;
//                the scanner drives the multiplexed common-anode display.
//  Ports (signals):
//    load        producer -> scanner  capture strobe for data/blank/dp
//    data_in     producer -> scanner  4 bits per digit, digit 0 = LS nibble
//    blank_in    producer -> scanner  1 = digit dark for its whole slot
//    dp_in       producer -> scanner  1 = decimal point lit on that digit
//    an          scanner  -> display  anode enables, active low
//    seg         scanner  -> display  cathodes {g,f,e,d,c,b,a}, active low
//    dp          scanner  -> display  decimal-point cathode, active low
//    frame_start scanner  -> producer pulse on active-buffer update
//  Revision    : 1.0  initial release
// ============================================================================
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   data_in;
    logic [NUM_DIGITS-1:0]     blank_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      dp;
    logic                      frame_start;

    modport master (
        output load, data_in, blank_in, dp_in,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  load, data_in, blank_in, dp_in,
        output an, seg, dp, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner
//  Description : Multiplexed common-anode 7-segment driver. A slot counter
//                on sys_clk times each digit; the first BLANK_CYCLES of every
//                slot keep all anodes off to suppress ghosting. Digit data is
//                double buffered: loads land in a pending buffer which is
//                copied to the active buffer only when the last digit's slot
//                ends, so a frame never mixes old and new data.
//  Ports:
//    sys_clk     in   system clock, rising edge
//    rst         in   asynchronous active-high reset
//    bus         slave modport of seven_seg_scanner_if (load/data/blank/dp
//                in; an/seg/dp/frame_start out)
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  wire logic           sys_clk,
    input  wire logic           rst,
    seven_seg_scanner_if.slave  bus
);

    localparam int c_CNT_W = $clog2(REFRESH_DIV);
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0]    c_BLANK    = c_CNT_W'(BLANK_CYCLES);
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF   = '1;
    localparam logic [NUM_DIGITS-1:0] c_AN_ONE   = NUM_DIGITS'(1);
    localparam logic [6:0]            c_SEG_OFF  = 7'h7F;

    typedef enum logic [0:0] {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    // Segment pattern {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Timing state
    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_idx;

    // Double buffer
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_blank;
    logic [NUM_DIGITS-1:0]   r_act_dp;

    // Registered outputs
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_start;

    // Next-state / output decode
    state_t                  w_state_next;
    logic                    w_wrap;
    logic                    w_transfer;
    logic [c_CNT_W-1:0]      w_cnt_next;
    logic [c_IDX_W-1:0]      w_idx_next;
    logic [3:0]              w_nibble;
    logic                    w_blank_sel;
    logic                    w_dp_sel;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [6:0]              w_seg_next;
    logic                    w_dp_next;
    logic                    w_fs_next;

    always_comb begin
        w_wrap       = (r_cnt == c_CNT_LAST);
        w_transfer   = w_wrap && (r_idx == c_IDX_LAST);
        w_cnt_next   = w_wrap ? '0 : r_cnt + 1'b1;
        w_idx_next   = r_idx;
        if (w_wrap) begin
            w_idx_next = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end

        // State follows the counter value it will hold next cycle, so the
        // GAP/ON boundary lines up exactly with cnt == BLANK_CYCLES.
        w_state_next = (w_cnt_next >= c_BLANK) ? ST_ON : ST_GAP;

        // Pre-computing the frame_start condition for the next cycle lets it
        // be a clean register bit asserted during the final cycle of the frame.
        w_fs_next    = (w_cnt_next == c_CNT_LAST) && (w_idx_next == c_IDX_LAST);

        w_nibble     = 4'h0;
        w_blank_sel  = 1'b1;
        w_dp_sel     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nibble    = r_act_data[4*i +: 4];
                w_blank_sel = r_act_blank[i];
                w_dp_sel    = r_act_dp[i];
            end
        end

        w_an_next  = c_AN_OFF;
        w_seg_next = c_SEG_OFF;
        w_dp_next  = 1'b1;
        if ((r_state == ST_ON) && !w_blank_sel) begin
            w_an_next  = ~(c_AN_ONE << r_idx);
            w_seg_next = hex_to_seg(w_nibble);
            w_dp_next  = ~w_dp_sel;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_GAP;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_an          <= c_AN_OFF;
            r_seg         <= c_SEG_OFF;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_idx         <= w_idx_next;
            r_an          <= w_an_next;
            r_seg         <= w_seg_next;
            r_dp          <= w_dp_next;
            r_frame_start <= w_fs_next;
        end
    end

    // A load in the transfer cycle bypasses pending so the new frame
    // already carries it.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_pend_data  <= '0;
            r_pend_blank <= '1;
            r_pend_dp    <= '0;
            r_act_data   <= '0;
            r_act_blank  <= '1;
            r_act_dp     <= '0;
        end else begin
            if (bus.load) begin
                r_pend_data  <= bus.data_in;
                r_pend_blank <= bus.blank_in;
                r_pend_dp    <= bus.dp_in;
            end
            if (w_transfer) begin
                r_act_data  <= bus.load ? bus.data_in  : r_pend_data;
                r_act_blank <= bus.load ? bus.blank_in : r_pend_blank;
                r_act_dp    <= bus.load ? bus.dp_in    : r_pend_dp;
            end
        end
    end

    assign bus.an          = r_an;
    assign bus.seg         = r_seg;
    assign bus.dp          = r_dp;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire
